fei4_rx_record_formatter: RTL and testbench

- Sits directly downstream of the FE-I4 receiver's 24-bit output FIFO, in the bus_clk domain.
- Pops decoded 24-bit FE-I4 records and classifies each one by record type.
- Tracks data-header framing, prefixes each record with a channel ID byte, and presents 32-bit words on a valid/ready stream toward the SRAM/readout FIFO.
- Provides framing-error and service-record monitoring counters.

---
 rtl/fei4_rx_record_formatter.sv | 141 ++++++++++++++
 tb/tb_fei4_rx_record_formatter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fei4_rx_record_formatter.sv
`default_nettype none
// ============================================================================
// Module      : fei4_rx_record_formatter
// Description : Pops decoded 24-bit FE-I4 records from the receiver's FWFT
//               FIFO, classifies them by type byte, tracks data-header
//               framing and presents {CHANNEL_ID, record} as 32-bit words on
//               a valid/ready stream. Keeps saturating monitoring counters.
// Ports       : bus_clk/bus_reset   - clock, async active-high reset
//               enable              - allow popping the upstream FIFO
//               fifo_empty/data/read- FWFT FIFO interface (read is a pop)
//               out_data/valid/ready- 32-bit output stream
//               dh_cnt, orphan_cnt, sr_cnt, last_bcid, in_frame - monitors
// Revision    : 1.0 - initial release
// ============================================================================
module fei4_rx_record_formatter #(
    parameter logic [7:0] CHANNEL_ID = 8'h01,
    parameter bit         DROP_SR    = 1'b0
) (
    input  logic        bus_clk,
    input  logic        bus_reset,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [23:0] fifo_data,
    output logic        fifo_read,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] dh_cnt,
    output logic [7:0]  orphan_cnt,
    output logic [7:0]  sr_cnt,
    output logic [9:0]  last_bcid,
    output logic        in_frame
);

    localparam logic [7:0] c_TYPE_DH = 8'hE9;
    localparam logic [7:0] c_TYPE_AR = 8'hEA;
    localparam logic [7:0] c_TYPE_VR = 8'hEC;
    localparam logic [7:0] c_TYPE_SR = 8'hEF;

    typedef enum logic [0:0] {
        NO_FRAME = 1'b0,
        FRAME    = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] dh_cnt_q;
    logic [7:0]  orphan_cnt_q;
    logic [7:0]  sr_cnt_q;
    logic [9:0]  last_bcid_q;

    logic [7:0]  w_type;
    logic        w_is_dh;
    logic        w_is_sr;
    logic        w_is_dr;
    logic        w_forward;

    assign w_type    = fifo_data[23:16];
    assign w_is_dh   = (w_type == c_TYPE_DH);
    assign w_is_sr   = (w_type == c_TYPE_SR);
    assign w_is_dr   = !(w_is_dh || w_is_sr ||
                         (w_type == c_TYPE_AR) || (w_type == c_TYPE_VR));
    assign w_forward = !(DROP_SR && w_is_sr);

    // Pop whenever the output register is free or being emptied this cycle.
    // Reset gates the strobe so nothing is consumed while the block is held.
    assign fifo_read = !bus_reset && enable && !fifo_empty &&
                       (!out_valid_q || out_ready);

    // Frame state: only a popped DH opens and only a popped SR closes.
    always_comb begin
        state_d = state_q;
        if (fifo_read) begin
            if (w_is_dh) begin
                state_d = FRAME;
            end else if (w_is_sr) begin
                state_d = NO_FRAME;
            end
        end
    end

    // Output register: a forwarded pop reloads it (no bubble even when the
    // current word is accepted on the same edge); otherwise an accepted word
    // empties it. Nothing changes while the word is stalled.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (fifo_read && w_forward) begin
            out_data_d  = {CHANNEL_ID, fifo_data};
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge bus_clk or posedge bus_reset) begin
        if (bus_reset) begin
            state_q     <= NO_FRAME;
            out_data_q  <= 32'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Monitoring counters, all saturating.
    always_ff @(posedge bus_clk or posedge bus_reset) begin
        if (bus_reset) begin
            dh_cnt_q     <= 16'd0;
            orphan_cnt_q <= 8'd0;
            sr_cnt_q     <= 8'd0;
            last_bcid_q  <= 10'd0;
        end else if (fifo_read) begin
            if (w_is_dh) begin
                if (dh_cnt_q != 16'hFFFF) begin
                    dh_cnt_q <= dh_cnt_q + 16'd1;
                end
                last_bcid_q <= fifo_data[9:0];
            end
            if (w_is_sr && (sr_cnt_q != 8'hFF)) begin
                sr_cnt_q <= sr_cnt_q + 8'd1;
            end
            if (w_is_dr && (state_q == NO_FRAME) && (orphan_cnt_q != 8'hFF)) begin
                orphan_cnt_q <= orphan_cnt_q + 8'd1;
            end
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign dh_cnt     = dh_cnt_q;
    assign orphan_cnt = orphan_cnt_q;
    assign sr_cnt     = sr_cnt_q;
    assign last_bcid  = last_bcid_q;
    assign in_frame   = (state_q == FRAME);

endmodule
`default_nettype wire

// File: tb/tb_fei4_rx_record_formatter.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module      : tb_fei4_rx_record_formatter
// Description : Scoreboard bench for fei4_rx_record_formatter. Two instances
//               (DROP_SR=0 and DROP_SR=1) each get their own FIFO model fed
//               with the same record stream; a reference model predicts
//               words, pops, out_valid and counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fei4_rx_record_formatter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        rdy = 1'b0;
    logic [1:0]  fe  = 2'b11;
    logic [23:0] fd [2];
    logic [1:0]  fr;
    logic [31:0] od [2];
    logic [1:0]  ov;
    logic [15:0] dh [2];
    logic [7:0]  orph [2];
    logic [7:0]  src [2];
    logic [9:0]  bcid [2];
    logic [1:0]  inf;

    always #5 clk = ~clk;

    fei4_rx_record_formatter #(.CHANNEL_ID(8'h01), .DROP_SR(1'b0)) u_dut0 (
        .bus_clk(clk), .bus_reset(rst), .enable(en), .fifo_empty(fe[0]),
        .fifo_data(fd[0]), .fifo_read(fr[0]), .out_data(od[0]), .out_valid(ov[0]),
        .out_ready(rdy), .dh_cnt(dh[0]), .orphan_cnt(orph[0]), .sr_cnt(src[0]),
        .last_bcid(bcid[0]), .in_frame(inf[0]));

    fei4_rx_record_formatter #(.CHANNEL_ID(8'h01), .DROP_SR(1'b1)) u_dut1 (
        .bus_clk(clk), .bus_reset(rst), .enable(en), .fifo_empty(fe[1]),
        .fifo_data(fd[1]), .fifo_read(fr[1]), .out_data(od[1]), .out_valid(ov[1]),
        .out_ready(rdy), .dh_cnt(dh[1]), .orphan_cnt(orph[1]), .sr_cnt(src[1]),
        .last_bcid(bcid[1]), .in_frame(inf[1]));

    // Environment and reference model state
    logic [23:0] fq [2][$];
    logic [31:0] sb [2][$];
    bit          popped [2];
    int          m_dh [2];
    int          m_orph [2];
    int          m_sr [2];
    logic [9:0]  m_bcid [2];
    bit          m_inf [2];
    bit          m_valid [2];
    int          n_chk = 0;
    int          n_err = 0;
    int          rst_gen = 0;

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", nm, i, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_dh[i] = 0; m_orph[i] = 0; m_sr[i] = 0; m_bcid[i] = 10'd0;
            m_inf[i] = 0; m_valid[i] = 0; popped[i] = 0;
            sb[i].delete();
        end
    endtask

    // Record semantics straight from the type byte.
    task automatic model_pop(input int i, input logic [23:0] rec, output bit fwd);
        logic [7:0] t;
        t = rec[23:16];
        fwd = 1;
        if (t == 8'hE9) begin
            m_dh[i] = (m_dh[i] < 65535) ? m_dh[i] + 1 : 65535;
            m_bcid[i] = rec[9:0];
            m_inf[i] = 1;
        end else if (t == 8'hEF) begin
            m_sr[i] = (m_sr[i] < 255) ? m_sr[i] + 1 : 255;
            m_inf[i] = 0;
            if (i == 1) fwd = 0;
        end else if (t != 8'hEA && t != 8'hEC) begin
            if (!m_inf[i]) m_orph[i] = (m_orph[i] < 255) ? m_orph[i] + 1 : 255;
        end
        if (fwd) sb[i].push_back({8'h01, rec});
    endtask

    task automatic push_rec(input logic [23:0] r);
        fq[0].push_back(r);
        fq[1].push_back(r);
    endtask

    task automatic apply_pops();
        for (int i = 0; i < 2; i++) begin
            if (popped[i] && fq[i].size() != 0) void'(fq[i].pop_front());
            popped[i] = 0;
        end
    endtask

    task automatic drive_fifo();
        for (int i = 0; i < 2; i++) begin
            fe[i] = (fq[i].size() == 0);
            fd[i] = fe[i] ? 24'($urandom) : fq[i][0];
        end
    endtask

    // One clock cycle: inputs change on the falling edge, the model predicts
    // the pop strobe and out_valid, then records what the DUT will pop.
    task automatic step(input logic e, input logic r);
        bit fwd;
        bit exp_pop;
        @(negedge clk);
        apply_pops();
        en = e; rdy = r;
        drive_fifo();
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_pop = e && (fq[i].size() != 0) && (!m_valid[i] || r);
            chk("out_valid", i, 32'(ov[i]), 32'(m_valid[i]));
            chk("fifo_read", i, 32'(fr[i]), 32'(exp_pop));
            fwd = 0;
            if (fr[i] && fq[i].size() != 0) begin
                popped[i] = 1;
                model_pop(i, fq[i][0], fwd);
            end
            if (fwd) m_valid[i] = 1;
            else if (r) m_valid[i] = 0;
        end
    endtask

    task automatic check_state();
        for (int i = 0; i < 2; i++) begin
            chk("dh_cnt", i, 32'(dh[i]), 32'(m_dh[i]));
            chk("orphan_cnt", i, 32'(orph[i]), 32'(m_orph[i]));
            chk("sr_cnt", i, 32'(src[i]), 32'(m_sr[i]));
            chk("last_bcid", i, 32'(bcid[i]), 32'(m_bcid[i]));
            chk("in_frame", i, 32'(inf[i]), 32'(m_inf[i]));
        end
    endtask

    task automatic drain(input int max_cycles);
        int k;
        k = 0;
        while ((fq[0].size() != 0 || fq[1].size() != 0 || m_valid[0] || m_valid[1] ||
                popped[0] || popped[1]) && k < max_cycles) begin
            step(1'b1, 1'b1);
            k++;
        end
        if (k >= max_cycles) begin
            n_chk++; n_err++;
            $display("FAIL drain_timeout: got %0d cycles, expected under %0d", k, max_cycles);
        end
        step(1'b0, 1'b0);
        check_state();
    endtask

    // Asynchronous reset pulse between clock edges; enable is held high
    // during the pulse to show the pop strobe stays forced low.
    task automatic do_reset();
        @(negedge clk);
        apply_pops();
        en = 1'b0;
        drive_fifo();
        #3;
        rst = 1'b1; en = 1'b1; rst_gen++;
        #0.5;
        for (int i = 0; i < 2; i++) begin
            chk("rst_out_valid", i, 32'(ov[i]), 32'd0);
            chk("rst_out_data", i, od[i], 32'd0);
            chk("rst_fifo_read", i, 32'(fr[i]), 32'd0);
            chk("rst_dh_cnt", i, 32'(dh[i]), 32'd0);
            chk("rst_orphan_cnt", i, 32'(orph[i]), 32'd0);
            chk("rst_sr_cnt", i, 32'(src[i]), 32'd0);
            chk("rst_last_bcid", i, 32'(bcid[i]), 32'd0);
            chk("rst_in_frame", i, 32'(inf[i]), 32'd0);
        end
        en = 1'b0;
        #0.5;
        rst = 1'b0;
        model_clear();
    endtask

    // Monitor: compares every accepted word against the scoreboard and
    // checks that a stalled word holds still.
    bit          hold [2];
    logic [31:0] hold_d [2];
    int          hold_gen [2];
    always @(negedge clk) begin
        #2;
        for (int i = 0; i < 2; i++) begin
            if (hold[i] && hold_gen[i] == rst_gen) begin
                chk("stall_valid", i, 32'(ov[i]), 32'd1);
                chk("stall_data", i, od[i], hold_d[i]);
            end
            hold[i] = 0;
            if (!rst && ov[i]) begin
                if (rdy) begin
                    if (sb[i].size() == 0) begin
                        n_chk++; n_err++;
                        $display("FAIL word inst%0d: got %h expected no word", i, od[i]);
                    end else begin
                        chk("word", i, od[i], sb[i].pop_front());
                    end
                end else begin
                    hold[i] = 1; hold_d[i] = od[i]; hold_gen[i] = rst_gen;
                end
            end
        end
    end

    function automatic logic [23:0] rand_rec();
        logic [7:0] t;
        case ($urandom_range(0, 5))
            0: t = 8'hE9;
            1: t = 8'hEA;
            2: t = 8'hEC;
            3: t = 8'hEF;
            default: t = 8'($urandom_range(0, 8'hE8));
        endcase
        return {t, 16'($urandom)};
    endfunction

    initial begin
        int npop;
        model_clear();
        fd[0] = 24'd0; fd[1] = 24'd0;
        repeat (2) @(negedge clk);
        do_reset();

        // Basic stream
        push_rec(24'hE90123); push_rec(24'h004567); push_rec(24'hEF0001);
        drain(20);
        chk("basic_dh_cnt", 0, 32'(dh[0]), 32'd1);
        chk("basic_last_bcid", 0, 32'(bcid[0]), 32'h123);
        chk("basic_sr_cnt", 0, 32'(src[0]), 32'd1);
        chk("basic_in_frame", 0, 32'(inf[0]), 32'd0);

        // Orphan detection
        do_reset();
        push_rec(24'h123456);
        drain(20);
        chk("orphan_cnt_const", 0, 32'(orph[0]), 32'd1);

        // Backpressure: only one pop while the output is stalled
        do_reset();
        for (int k = 0; k < 4; k++) push_rec(rand_rec());
        npop = 0;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0);
            if (popped[0]) npop++;
        end
        chk("stall_pops", 0, 32'(npop), 32'd1);
        drain(30);

        // Dropped service record (instance 1 drops, instance 0 forwards)
        do_reset();
        push_rec(24'hE90000); push_rec(24'hEF0002); push_rec(24'hEA0010);
        drain(20);
        chk("drop_sr_cnt", 1, 32'(src[1]), 32'd1);

        // Randomized traffic with random enable and backpressure
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) != 0 && fq[0].size() < 8) push_rec(rand_rec());
            step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) < 7));
        end
        drain(100);

        // Orphan counter saturation
        do_reset();
        for (int k = 0; k < 260; k++) push_rec({8'($urandom_range(0, 8'hE8)), 16'($urandom)});
        drain(400);
        chk("orphan_sat", 0, 32'(orph[0]), 32'hFF);

        // Reset while a word is pending, then normal operation
        for (int k = 0; k < 6; k++) push_rec(rand_rec());
        repeat (3) step(1'b1, 1'b0);
        chk("pre_reset_valid", 0, 32'(m_valid[0]), 32'(ov[0]));
        do_reset();
        push_rec(24'hE903FF); push_rec(24'h0A0B0C);
        drain(40);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
